// File: rtl/spi_mem_pkg.sv
// -----------------------------------------------------------------------------
// spi_mem_pkg
// Shared definitions for the SPI memory controller:
//   - SPI command encodings carried in rx_data[9:8]
//   - controller FSM state encoding
//   - word widths and a small command-classification helper
// No ports (package).
// -----------------------------------------------------------------------------
package spi_mem_pkg;

  localparam int RX_W   = 10;  // SPI slave word: [9:8] command, [7:0] payload
  localparam int DATA_W = 8;   // memory data width

  typedef enum logic [1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ACCESS  = 2'b01,
    ST_RD_WAIT = 2'b10,
    ST_RESP    = 2'b11
  } state_e;

  // Commands that need a memory access (the others only latch an address).
  function automatic logic is_mem_cmd(input cmd_e c);
    return (c == CMD_WR_DATA) || (c == CMD_RD_DATA);
  endfunction

endpackage

// File: rtl/spi_mem_arb.sv
// -----------------------------------------------------------------------------
// spi_mem_arb
// Fixed-priority arbiter between the SPI word stream and the host port, plus a
// one-entry pending register for SPI words that arrive while the controller is
// busy.
//   - In IDLE a pending word wins over a fresh rx word, and any SPI word wins
//     over host_req.
//   - Outside IDLE an rx word is parked in the pending register; if it is
//     already full the new word is dropped and ovf_err latches until reset.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   idle               controller FSM is in IDLE this cycle
//   rx_valid, rx_data  SPI slave word strobe and word
//   host_req           host access request
//   spi_sel, spi_word  an SPI word is being consumed this cycle, and which one
//   host_sel           host request granted this cycle
//   ovf_err            sticky pending-buffer overflow
// -----------------------------------------------------------------------------
module spi_mem_arb
  import spi_mem_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            idle,
  input  logic            rx_valid,
  input  logic [RX_W-1:0] rx_data,
  input  logic            host_req,
  output logic            spi_sel,
  output logic [RX_W-1:0] spi_word,
  output logic            host_sel,
  output logic            ovf_err
);

  logic            pend_vld;
  logic [RX_W-1:0] pend_data;

  always_comb begin
    spi_sel  = idle && (pend_vld || rx_valid);
    spi_word = pend_vld ? pend_data : rx_data;
    host_sel = idle && !(pend_vld || rx_valid) && host_req;
  end

  // Control: pending occupancy and the sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_vld <= 1'b0;
      ovf_err  <= 1'b0;
    end else if (rx_valid) begin
      if (idle) begin
        // Pending word (if any) is consumed this cycle; the fresh word refills
        // it, otherwise the fresh word is consumed directly.
        pend_vld <= pend_vld;
      end else if (!pend_vld) begin
        pend_vld <= 1'b1;
      end else begin
        ovf_err  <= 1'b1;
      end
    end else if (idle) begin
      pend_vld <= 1'b0;
    end
  end

  // Data: the parked word itself; meaningless while pend_vld is low.
  always_ff @(posedge clk) begin
    if (rx_valid && ((idle && pend_vld) || (!idle && !pend_vld))) begin
      pend_data <= rx_data;
    end
  end

endmodule

// File: rtl/spi_mem_ctrl.sv
// -----------------------------------------------------------------------------
// spi_mem_ctrl
// Bridges an SPI slave word interface and a host port onto a single-port
// synchronous memory.
//   Commands (rx_data[9:8]): 00 latch wr_addr, 01 write payload at wr_addr,
//   10 latch rd_addr, 11 read at rd_addr (payload ignored).
//   Access timing relative to the selecting IDLE cycle T:
//     T+1 mem_en (+mem_we, host_gnt for host), T+2 memory returns data,
//     T+3 tx_valid / host_rvalid with the read data.
// Optional feature: define SPI_MEM_CTRL_AUTOINC_EN to post-increment wr_addr
// after each 01 command and rd_addr after each 11 command (wrapping).
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   rx_data, rx_valid               SPI slave word and strobe
//   tx_data, tx_valid               read data to SPI slave (held until next read)
//   mem_en, mem_we, mem_addr,
//   mem_wdata, mem_rdata            memory port (rdata one cycle after read)
//   host_req, host_we, host_addr,
//   host_wdata, host_gnt,
//   host_rvalid, host_rdata         host access port
//   ovf_err                         sticky pending-buffer overflow
// -----------------------------------------------------------------------------
module spi_mem_ctrl
  import spi_mem_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [RX_W-1:0]   rx_data,
  input  logic              rx_valid,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic              ovf_err
);

  state_e state, state_nxt;

  logic              spi_sel, host_sel;
  logic [RX_W-1:0]   spi_word;
  cmd_e              spi_cmd;
  logic [DATA_W-1:0] spi_pl;
  logic              start;

  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic [ADDR_W-1:0] op_addr;
  logic [DATA_W-1:0] op_wdata;
  logic              op_we, op_host;

  function automatic logic [ADDR_W-1:0] addr_next(input logic [ADDR_W-1:0] a);
`ifdef SPI_MEM_CTRL_AUTOINC_EN
    return a + ADDR_W'(1);
`else
    return a;
`endif
  endfunction

  spi_mem_arb u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .idle     (state == ST_IDLE),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .host_req (host_req),
    .spi_sel  (spi_sel),
    .spi_word (spi_word),
    .host_sel (host_sel),
    .ovf_err  (ovf_err)
  );

  assign spi_cmd = cmd_e'(spi_word[9:8]);
  assign spi_pl  = spi_word[7:0];
  // Address-latch commands are absorbed in IDLE; they do not start an access
  // but still block the host for that cycle.
  assign start   = (spi_sel && is_mem_cmd(spi_cmd)) || host_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    host_gnt    = 1'b0;
    tx_valid    = 1'b0;
    host_rvalid = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_ACCESS;
      end
      ST_ACCESS: begin
        mem_en    = 1'b1;
        mem_we    = op_we;
        mem_addr  = op_addr;
        mem_wdata = op_we ? op_wdata : '0;
        host_gnt  = op_host;
        state_nxt = op_we ? ST_IDLE : ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        state_nxt = ST_RESP;
      end
      ST_RESP: begin
        tx_valid    = !op_host;
        host_rvalid = op_host;
        state_nxt   = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // IDLE -> ACCESS: capture the selected operation and update the address
  // pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr <= '0;
      rd_addr <= '0;
      op_we   <= 1'b0;
      op_host <= 1'b0;
    end else if (state == ST_IDLE) begin
      if (spi_sel) begin
        case (spi_cmd)
          CMD_WR_ADDR: wr_addr <= spi_pl[ADDR_W-1:0];
          CMD_RD_ADDR: rd_addr <= spi_pl[ADDR_W-1:0];
          CMD_WR_DATA: begin
            op_we   <= 1'b1;
            op_host <= 1'b0;
            wr_addr <= addr_next(wr_addr);
          end
          default: begin
            op_we   <= 1'b0;
            op_host <= 1'b0;
            rd_addr <= addr_next(rd_addr);
          end
        endcase
      end else if (host_sel) begin
        op_we   <= host_we;
        op_host <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == ST_IDLE) begin
      if (spi_sel) begin
        op_addr  <= (spi_cmd == CMD_WR_DATA) ? wr_addr : rd_addr;
        op_wdata <= spi_pl;
      end else if (host_sel) begin
        op_addr  <= host_addr;
        op_wdata <= host_wdata;
      end
    end
  end

  // RD_WAIT -> RESP: memory data is valid now; route it to the requester and
  // hold it until the next read for that requester.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_data    <= '0;
      host_rdata <= '0;
    end else if (state == ST_RD_WAIT) begin
      if (op_host) host_rdata <= mem_rdata;
      else         tx_data    <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_spi_mem_ctrl.sv
module tb_spi_mem_ctrl;

  logic       clk;
  logic       rst_n;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       mem_en;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       host_req;
  logic       host_we;
  logic [7:0] host_addr;
  logic [7:0] host_wdata;
  logic       host_gnt;
  logic       host_rvalid;
  logic [7:0] host_rdata;
  logic       ovf_err;

  int n_chk = 0;
  int n_err = 0;

  // Reference model state
  logic [7:0] ref_mem [256];
  logic [7:0] ref_wr, ref_rd, ref_tx;

  // Device memory driven by the DUT's memory port
  logic [7:0] dev_mem [256];
  logic       dev_init = 1'b0;

  spi_mem_ctrl #(.ADDR_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .host_req   (host_req),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_gnt   (host_gnt),
    .host_rvalid(host_rvalid),
    .host_rdata (host_rdata),
    .ovf_err    (ovf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] init_val(input int a);
    if (a == 'h12) return 8'h3C;
    return 8'(a * 37 + 11);
  endfunction

  function automatic logic [7:0] inc(input logic [7:0] a);
`ifdef SPI_MEM_CTRL_AUTOINC_EN
    return a + 8'd1;
`else
    return a;
`endif
  endfunction

  always @(posedge clk) begin
    if (!dev_init) begin
      for (int i = 0; i < 256; i++) dev_mem[i] <= init_val(i);
      dev_init  <= 1'b1;
      mem_rdata <= 8'hEE;
    end else begin
      if (mem_en && mem_we) dev_mem[mem_addr] <= mem_wdata;
      mem_rdata <= (mem_en && !mem_we) ? dev_mem[mem_addr] : 8'hEE;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk8({tag, "_tx_data"},    tx_data,     8'h00);
    chk1({tag, "_tx_valid"},   tx_valid,    1'b0);
    chk1({tag, "_mem_en"},     mem_en,      1'b0);
    chk1({tag, "_mem_we"},     mem_we,      1'b0);
    chk8({tag, "_mem_addr"},   mem_addr,    8'h00);
    chk8({tag, "_mem_wdata"},  mem_wdata,   8'h00);
    chk1({tag, "_host_gnt"},   host_gnt,    1'b0);
    chk1({tag, "_host_rvalid"},host_rvalid, 1'b0);
    chk8({tag, "_host_rdata"}, host_rdata,  8'h00);
    chk1({tag, "_ovf_err"},    ovf_err,     1'b0);
  endtask

  // One SPI word issued while idle, checked against the command rules.
  task automatic spi_cmd(input logic [9:0] w);
    logic [7:0] pl;
    pl       = w[7:0];
    rx_data  = w;
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
    case (w[9:8])
      2'b00: begin
        ref_wr = pl;
        chk1("wa_no_mem_en", mem_en, 1'b0);
      end
      2'b10: begin
        ref_rd = pl;
        chk1("ra_no_mem_en", mem_en, 1'b0);
      end
      2'b01: begin
        chk1("wr_mem_en", mem_en, 1'b1);
        chk1("wr_mem_we", mem_we, 1'b1);
        chk8("wr_addr", mem_addr, ref_wr);
        chk8("wr_data", mem_wdata, pl);
        ref_mem[ref_wr] = pl;
        ref_wr = inc(ref_wr);
        step();
        chk1("wr_single_en", mem_en, 1'b0);
      end
      default: begin
        chk1("rd_mem_en", mem_en, 1'b1);
        chk1("rd_mem_we", mem_we, 1'b0);
        chk8("rd_addr", mem_addr, ref_rd);
        step();
        chk1("rd_no_early_tx", tx_valid, 1'b0);
        step();
        ref_tx = ref_mem[ref_rd];
        chk1("rd_tx_valid", tx_valid, 1'b1);
        chk8("rd_tx_data", tx_data, ref_tx);
        ref_rd = inc(ref_rd);
        step();
        chk1("rd_tx_pulse", tx_valid, 1'b0);
        chk8("rd_tx_hold", tx_data, ref_tx);
      end
    endcase
  endtask

  task automatic host_op(input logic we, input logic [7:0] a, input logic [7:0] d);
    host_req   = 1'b1;
    host_we    = we;
    host_addr  = a;
    host_wdata = d;
    step();
    chk1("h_gnt", host_gnt, 1'b1);
    chk1("h_mem_en", mem_en, 1'b1);
    chk1("h_mem_we", mem_we, we);
    chk8("h_mem_addr", mem_addr, a);
    if (we) chk8("h_mem_wdata", mem_wdata, d);
    host_req = 1'b0;
    if (we) ref_mem[a] = d;
    step();
    chk1("h_gnt_pulse", host_gnt, 1'b0);
    chk1("h_single_en", mem_en, 1'b0);
    if (!we) begin
      step();
      chk1("h_rvalid", host_rvalid, 1'b1);
      chk8("h_rdata", host_rdata, ref_mem[a]);
      chk1("h_no_tx_valid", tx_valid, 1'b0);
      step();
      chk1("h_rvalid_pulse", host_rvalid, 1'b0);
    end
    chk8("h_tx_hold", tx_data, ref_tx);
  endtask

  initial begin
    logic       hw;
    logic [7:0] ha, hd;
    rst_n      = 1'b0;
    rx_data    = '0;
    rx_valid   = 1'b0;
    host_req   = 1'b0;
    host_we    = 1'b0;
    host_addr  = '0;
    host_wdata = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    ref_wr = 8'h00;
    ref_rd = 8'h00;
    ref_tx = 8'h00;

    repeat (3) step();
    chk_zero("rst");
    rst_n = 1'b1;
    step();

    // Read of 0x12 returning 0x3C, tx_valid three cycles after the read word
    spi_cmd(10'h212);
    spi_cmd(10'h300);

    // Write 0xA5 at 0x12
    spi_cmd(10'h012);
    spi_cmd(10'h1A5);

    // Host read 0x40 collides with SPI write: SPI first, host after IDLE
    rx_data    = 10'h155;
    rx_valid   = 1'b1;
    host_req   = 1'b1;
    host_we    = 1'b0;
    host_addr  = 8'h40;
    host_wdata = 8'h00;
    step();
    rx_valid = 1'b0;
    chk1("col_spi_en", mem_en, 1'b1);
    chk1("col_spi_we", mem_we, 1'b1);
    chk8("col_spi_addr", mem_addr, ref_wr);
    chk8("col_spi_data", mem_wdata, 8'h55);
    chk1("col_no_gnt", host_gnt, 1'b0);
    ref_mem[ref_wr] = 8'h55;
    ref_wr = inc(ref_wr);
    step();
    chk1("col_idle_en", mem_en, 1'b0);
    chk1("col_idle_gnt", host_gnt, 1'b0);
    step();
    chk1("col_gnt", host_gnt, 1'b1);
    chk1("col_h_en", mem_en, 1'b1);
    chk1("col_h_we", mem_we, 1'b0);
    chk8("col_h_addr", mem_addr, 8'h40);
    host_req = 1'b0;
    step();
    chk1("col_gnt_pulse", host_gnt, 1'b0);
    step();
    chk1("col_rvalid", host_rvalid, 1'b1);
    chk8("col_rdata", host_rdata, ref_mem[8'h40]);
    step();
    chk1("col_rvalid_pulse", host_rvalid, 1'b0);

    // Host write, read back through SPI
    host_op(1'b1, 8'h41, 8'h99);
    spi_cmd(10'h241);
    spi_cmd(10'h300);

    // Pending capture during RD_WAIT, second word dropped with overflow
    rx_data  = 10'h300;
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
    chk8("pend_rd_addr", mem_addr, ref_rd);
    step();
    rx_data  = 10'h166;
    rx_valid = 1'b1;
    step();
    ref_tx = ref_mem[ref_rd];
    chk1("pend_tx_valid", tx_valid, 1'b1);
    chk8("pend_tx_data", tx_data, ref_tx);
    chk1("pend_no_ovf_yet", ovf_err, 1'b0);
    ref_rd  = inc(ref_rd);
    rx_data = 10'h177;
    step();
    rx_valid = 1'b0;
    chk1("ovf_set", ovf_err, 1'b1);
    chk1("pend_idle_en", mem_en, 1'b0);
    step();
    chk1("pend_srv_en", mem_en, 1'b1);
    chk1("pend_srv_we", mem_we, 1'b1);
    chk8("pend_srv_addr", mem_addr, ref_wr);
    chk8("pend_srv_data", mem_wdata, 8'h66);
    ref_mem[ref_wr] = 8'h66;
    ref_wr = inc(ref_wr);
    step();
    chk1("pend_single_en", mem_en, 1'b0);
    step();
    chk1("drop_no_en", mem_en, 1'b0);
    step();
    chk1("drop_no_en2", mem_en, 1'b0);

    // Randomized SPI commands and host accesses against the model
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 9) < 2) begin
        hw = 1'($urandom_range(0, 1));
        ha = 8'($urandom);
        hd = 8'($urandom);
        host_op(hw, ha, hd);
      end else begin
        spi_cmd(10'($urandom));
      end
    end
    chk1("ovf_sticky", ovf_err, 1'b1);

    // Address wrap: two writes starting at 0xFF
    spi_cmd(10'h0FF);
    spi_cmd(10'h111);
    spi_cmd(10'h122);
    spi_cmd(10'h2FF);
    spi_cmd(10'h300);
    spi_cmd(10'h200);
    spi_cmd(10'h300);

    // Reset during RD_WAIT
    rx_data  = 10'h300;
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    chk_zero("mid_rst");
    step();
    step();
    rst_n  = 1'b1;
    ref_wr = 8'h00;
    ref_rd = 8'h00;
    ref_tx = 8'h00;
    for (int i = 0; i < 5; i++) begin
      step();
      chk1("post_rst_tx_valid", tx_valid, 1'b0);
      chk1("post_rst_mem_en", mem_en, 1'b0);
      chk1("post_rst_ovf", ovf_err, 1'b0);
    end

    // Addresses default to 0 after reset
    spi_cmd(10'h355);
    spi_cmd(10'h1AB);
    spi_cmd(10'h200);
    spi_cmd(10'h300);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/spi_mem_ctrl.md
SPI_MEM_CTRL -- requirements
Module: spi_mem_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, 8, memory address width (1..8); address taken from rx_data[ADDR_W-1:0].
REQ-002 SHALL have ports: clk  in  1  clock, all logic on rising edge.
REQ-003 SHALL have ports: rst_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have ports: rx_data  in  10  SPI slave word, [9:8] command, [7:0] payload; rx_valid  in  1  one-cycle word strobe.
REQ-005 SHALL have ports: tx_data  out  8  read data to SPI slave; tx_valid  out  1  one-cycle strobe.
REQ-006 SHALL have ports: mem_en  out  1; mem_we  out  1; mem_addr  out  ADDR_W; mem_wdata  out  8; mem_rdata  in  8, valid the cycle after mem_en with mem_we=0.
REQ-007 SHALL have ports: host_req  in  1; host_we  in  1; host_addr  in  ADDR_W; host_wdata  in  8; host_gnt  out  1; host_rvalid  out  1; host_rdata  out  8.
REQ-008 SHALL have ports: ovf_err  out  1  sticky pending-buffer overflow flag.

Function
REQ-009 SHALL decode rx_data[9:8]: 00 latch wr_addr; 01 write payload at wr_addr; 10 latch rd_addr; 11 read at rd_addr, payload ignored.
REQ-010 SHALL run FSM IDLE, ACCESS, RD_WAIT, RESP; write IDLE->ACCESS->IDLE; read IDLE->ACCESS->RD_WAIT->RESP->IDLE.
REQ-011 SHALL handle address-latch commands in IDLE without a memory access; address registered at next edge.
REQ-012 SHALL, for rx_valid in cycle T in IDLE, drive mem_en (and mem_we for writes) in T+1 only; for reads, tx_data/tx_valid in T+3.
REQ-013 SHALL hold tx_data stable from tx_valid until the next read response (slave shifts it over 8 cycles).
REQ-014 SHALL, in IDLE, give SPI (pending or new word) fixed priority over host_req; host waits, no timeout.
REQ-015 SHALL, for host_req sampled in IDLE cycle T with no SPI work, assert host_gnt and mem_en for one cycle in T+1; host read: host_rdata/host_rvalid in T+3.
REQ-016 SHALL require host fields stable while host_req=1 until host_gnt; host_gnt is a one-cycle pulse.
REQ-017 SHALL capture rx_valid arriving outside IDLE into a one-entry pending register, serviced on next IDLE before host.
REQ-018 SHALL, on rx_valid with pending full, drop the new word and set ovf_err until reset.
REQ-019 SHALL use wr_addr/rd_addr of 0 when no address was latched since reset.
REQ-020 SHALL keep mem_en, mem_we, host_gnt, tx_valid, host_rvalid low outside their specified cycles.

Reset
REQ-021 SHALL on rst_n=0 force FSM IDLE, all outputs 0, wr_addr=rd_addr=0, pending empty, ovf_err=0.
REQ-022 SHALL abandon any in-flight access on reset mid-operation; no late tx_valid/host_rvalid after release.

Configuration
REQ-023 SHALL, with SPI_MEM_CTRL_AUTOINC_EN defined, post-increment wr_addr after each 01 and rd_addr after each 11, wrapping 2^ADDR_W-1 -> 0.
REQ-024 SHALL, without SPI_MEM_CTRL_AUTOINC_EN, leave addresses unchanged except by 00/10 commands.

Structure
REQ-025 SHALL place command encodings (CMD_WR_ADDR, CMD_WR_DATA, CMD_RD_ADDR, CMD_RD_DATA) and FSM state encoding in package spi_mem_pkg.
REQ-026 SHALL isolate fixed-priority arbitration plus pending register in sub-module spi_mem_arb.

Verification
REQ-027 SHALL cover: rx 0x012 then 0x1A5 -> mem write addr 0x12 data 0xA5, single mem_en cycle.
REQ-028 SHALL cover: rx 0x212 then 0x300, mem_rdata=0x3C -> tx_data=0x3C, tx_valid exactly 3 cycles after second rx_valid.
REQ-029 SHALL cover: host_req read addr 0x40 same cycle as rx 0x155 -> SPI write first, host_gnt after return to IDLE, host_rdata correct.
REQ-030 SHALL cover: rx_valid during RD_WAIT, then another before service -> first serviced from pending, second dropped, ovf_err=1.
REQ-031 SHALL cover: AUTOINC_EN, wr_addr 0xFF, two 01 commands -> writes at 0xFF then 0x00.
REQ-032 SHALL cover: rst_n low during RD_WAIT -> all outputs 0, no tx_valid after release.
